alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the 32-bit ALU (yAlu, ops AND/OR/ADD/SUB).
- Holds the 32x32 register file and reads two source operands, with write-back bypass.
- Selects register or immediate for operand B.
- Presents a, b and op to the ALU through a one-entry valid/ready pipeline register with stall and flush.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/reg_file.sv | 32 +++
 rtl/alu_operand_stage.sv | 92 +++++++++
 tb/tb_alu_operand_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, ALU op encodings and op legality check
// for the operand issue stage.
package alu_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int RW   = 5;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;

   function automatic logic is_legal_op(input logic [2:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports, one sync write
// port, x0 hardwired to zero, async clear.
module reg_file
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [RW-1:0]   ra1,
   output logic [XLEN-1:0] rd1,
   input  logic [RW-1:0]   ra2,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [RW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] mem [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
   assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand read with write-back bypass, immediate select and a
// one-entry valid/ready register feeding the ALU.
module alu_operand_stage
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RW-1:0]   rs1,
   input  logic [RW-1:0]   rs2,
   input  logic [RW-1:0]   rd,
   input  logic [XLEN-1:0] imm,
   input  logic            use_imm,
   input  logic [2:0]      op,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_op,
   output logic [RW-1:0]   out_rd,
   output logic            op_err
);

   logic [XLEN-1:0] rf_a, rf_b;
   logic [XLEN-1:0] a_nxt, b_reg, b_nxt;
   logic [RW-1:0]   cap_rs1, cap_rs2;
   logic            cap_imm;
   logic            load, hit_a, hit_b;

   reg_file u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1   (rs1),
      .rd1   (rf_a),
      .ra2   (rs2),
      .rd2   (rf_b),
      .we    (wb_en),
      .wa    (wb_rd),
      .wd    (wb_data)
   );

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready && !flush;

   assign a_nxt = (rs1 == '0) ? '0 :
                  (wb_en && wb_rd == rs1) ? wb_data : rf_a;
   assign b_reg = (rs2 == '0) ? '0 :
                  (wb_en && wb_rd == rs2) ? wb_data : rf_b;
   assign b_nxt = use_imm ? imm : b_reg;

   // keep a stalled entry's operands current with write-back
   assign hit_a = wb_en && wb_rd != '0 && wb_rd == cap_rs1;
   assign hit_b = wb_en && wb_rd != '0 && wb_rd == cap_rs2
                  && !cap_imm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= OP_AND;
         out_rd    <= '0;
         op_err    <= 1'b0;
         cap_rs1   <= '0;
         cap_rs2   <= '0;
         cap_imm   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         alu_a     <= a_nxt;
         alu_b     <= b_nxt;
         alu_op    <= op;
         out_rd    <= rd;
         op_err    <= !is_legal_op(op);
         cap_rs1   <= rs1;
         cap_rs2   <= rs2;
         cap_imm   <= use_imm;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end else if (out_valid) begin
         if (hit_a) alu_a <= wb_data;
         if (hit_b) alu_b <= wb_data;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench: stimulus queues expected ALU entries, a
// negedge monitor pops and compares each delivered entry.
module tb_alu_operand_stage;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        use_imm;
   logic [2:0]  op;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [4:0]  out_rd;
   logic        op_err;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   n_exp = 0;
   int   n_del = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .imm       (imm),
      .use_imm   (use_imm),
      .op        (op),
      .flush     (flush),
      .wb_en     (wb_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .out_rd    (out_rd),
      .op_err    (op_err)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] o, input logic [4:0] d,
                       input logic e);
      exp_t x;
      x.a = a; x.b = b; x.op = o; x.rd = d; x.err = e;
      sb.push_back(x);
      n_exp++;
   endtask

   task automatic drop_last();
      void'(sb.pop_back());
      n_exp--;
   endtask

   task automatic set_instr(input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] d, input logic [31:0] im,
                            input logic ui, input logic [2:0] o);
      in_valid = 1'b1;
      rs1 = s1; rs2 = s2; rd = d;
      imm = im; use_imm = ui; op = o;
   endtask

   task automatic wb(input logic en, input logic [4:0] r,
                     input logic [31:0] d);
      wb_en = en; wb_rd = r; wb_data = d;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_del++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_entry actual=a:%h rd:%0d required=none",
                     alu_a, out_rd);
         end else begin
            mon_e = sb.pop_front();
            chk("mon_a", alu_a, mon_e.a);
            chk("mon_b", alu_b, mon_e.b);
            chk("mon_op", {29'd0, alu_op}, {29'd0, mon_e.op});
            chk("mon_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
            chk("mon_err", {31'd0, op_err}, {31'd0, mon_e.err});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
      imm = '0; use_imm = 1'b0; op = 3'b000;
      flush = 1'b0; out_ready = 1'b1;
      wb(1'b0, 5'd0, 32'd0);
      tick(); tick();
      reset = 1'b0;

      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_a", alu_a, 32'd0);
      chk("rst_b", alu_b, 32'd0);
      chk("rst_op", {29'd0, alu_op}, 32'd0);
      chk("rst_err", {31'd0, op_err}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1: basic register read
      wb(1'b1, 5'd5, 32'd7); tick();
      wb(1'b1, 5'd6, 32'd3); tick();
      wb(1'b0, 5'd0, 32'd0);
      set_instr(5'd5, 5'd6, 5'd1, 32'd0, 1'b0, 3'b010);
      push(32'd7, 32'd3, 3'b010, 5'd1, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      tick();

      // 2: same-cycle bypass, then RF holds the value
      set_instr(5'd5, 5'd6, 5'd2, 32'd0, 1'b0, 3'b000);
      wb(1'b1, 5'd5, 32'hDEAD_BEEF);
      push(32'hDEAD_BEEF, 32'd3, 3'b000, 5'd2, 1'b0);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      set_instr(5'd6, 5'd5, 5'd3, 32'd0, 1'b0, 3'b001);
      push(32'd3, 32'hDEAD_BEEF, 3'b001, 5'd3, 1'b0);
      tick();

      // 3: x0 reads zero even with a write in flight
      set_instr(5'd0, 5'd0, 5'd4, 32'd0, 1'b0, 3'b010);
      wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      push(32'd0, 32'd0, 3'b010, 5'd4, 1'b0);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      in_valid = 1'b0;
      tick();

      // 4: stall with operand refresh
      out_ready = 1'b0;
      set_instr(5'd5, 5'd6, 5'd5, 32'd0, 1'b0, 3'b110);
      push(32'hDEAD_BEEF, 32'h0000_1234, 3'b110, 5'd5, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("t4_in_ready_stall", {31'd0, in_ready}, 32'd0);
      chk("t4_b_before", alu_b, 32'd3);
      wb(1'b1, 5'd6, 32'h0000_1234);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      chk("t4_b_refresh", alu_b, 32'h0000_1234);
      chk("t4_a_hold", alu_a, 32'hDEAD_BEEF);
      set_instr(5'd6, 5'd0, 5'd6, 32'h0000_00FF, 1'b1, 3'b000);
      push(32'h0000_1234, 32'h0000_00FF, 3'b000, 5'd6, 1'b0);
      tick();
      chk("t4_in_ready_blocked", {31'd0, in_ready}, 32'd0);
      chk("t4_rd_hold", {27'd0, out_rd}, 32'd5);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t4_next_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_next_rd", {27'd0, out_rd}, 32'd6);
      tick();
      chk("t4_drain", {31'd0, out_valid}, 32'd0);

      // 5: flush beats accept; write-back still lands
      out_ready = 1'b0;
      set_instr(5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 3'b010);
      push(32'hDEAD_BEEF, 32'h0000_1234, 3'b010, 5'd7, 1'b0);
      tick();
      drop_last();
      flush = 1'b1;
      set_instr(5'd5, 5'd0, 5'd8, 32'd0, 1'b0, 3'b110);
      wb(1'b1, 5'd9, 32'hA5A5_0009);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      wb(1'b0, 5'd0, 32'd0);
      chk("t5_flushed", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("t5_still_empty", {31'd0, out_valid}, 32'd0);
      set_instr(5'd9, 5'd0, 5'd9, 32'd0, 1'b0, 3'b001);
      push(32'hA5A5_0009, 32'd0, 3'b001, 5'd9, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();

      // 6: illegal op, then async reset while held
      out_ready = 1'b0;
      set_instr(5'd6, 5'd0, 5'd10, 32'h0000_0010, 1'b1, 3'b111);
      tick();
      in_valid = 1'b0;
      chk("t6_err", {31'd0, op_err}, 32'd1);
      chk("t6_b_imm", alu_b, 32'h0000_0010);
      chk("t6_op", {29'd0, alu_op}, 32'd7);
      chk("t6_a", alu_a, 32'h0000_1234);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_err", {31'd0, op_err}, 32'd0);
      chk("t6_rst_b", alu_b, 32'd0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      set_instr(5'd5, 5'd9, 5'd11, 32'd0, 1'b0, 3'b010);
      push(32'd0, 32'd0, 3'b010, 5'd11, 1'b0);
      tick();
      set_instr(5'd6, 5'd6, 5'd12, 32'd0, 1'b0, 3'b110);
      push(32'd0, 32'd0, 3'b110, 5'd12, 1'b0);
      tick();
      in_valid = 1'b0;
      tick(); tick();

      chk("sb_empty", sb.size(), 32'd0);
      chk("delivered", n_del, n_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
